// File: rtl/hash160_byte_tx_if.sv
// Digest-in / symbol-out handshake bundle for hash160_byte_tx.
// The master side supplies the digest and the downstream ready.
interface hash160_byte_tx_if;
    logic         i_valid;
    logic [159:0] i_digest;
    logic         o_ready;
    logic [7:0]   o_data;
    logic         o_valid;
    logic         i_ready;
    logic         o_last;

    modport master (
        output i_valid, i_digest, i_ready,
        input  o_ready, o_data, o_valid, o_last
    );

    modport slave (
        input  i_valid, i_digest, i_ready,
        output o_ready, o_data, o_valid, o_last
    );
endinterface

// File: rtl/hash160_byte_tx.sv
// Hash160 digest serializer: captures 160 bits in one cycle and
// streams them MSB first as raw bytes or lowercase ASCII hex.
module hash160_byte_tx #(
    parameter bit HEX_ASCII = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    hash160_byte_tx_if.slave  bus
);

    localparam logic [5:0]  LAST = HEX_ASCII ? 6'd39 : 6'd19;
    localparam int unsigned STEP = HEX_ASCII ? 4 : 8;

    typedef enum logic {IDLE, SEND} state_e;

    state_e         state_q, state_d;
    logic [159:0]   shreg_q, shreg_d;
    logic [5:0]     cnt_q, cnt_d;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        hex_char = (n < 4'd10) ? {4'h3, n} : 8'h57 + {4'h0, n};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.i_valid) begin
                    shreg_d = bus.i_digest;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.i_ready) begin
                    if (cnt_q == LAST) begin
                        state_d = IDLE;
                    end else begin
                        shreg_d = shreg_q << STEP;
                        cnt_d   = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Idle forces o_data to zero so hex mode does not show '0' there.
    always_comb begin
        bus.o_ready = 1'b1;
        bus.o_valid = 1'b0;
        bus.o_last  = 1'b0;
        bus.o_data  = 8'h00;
        if (state_q == SEND) begin
            bus.o_ready = 1'b0;
            bus.o_valid = 1'b1;
            bus.o_last  = (cnt_q == LAST);
            bus.o_data  = HEX_ASCII ? hex_char(shreg_q[159:156])
                                    : shreg_q[159:152];
        end
    end

endmodule

// File: tb/tb_hash160_byte_tx.sv
// Scoreboard bench for hash160_byte_tx: one raw and one hex instance,
// expected symbols queued at capture, popped by per-port monitors.
module tb_hash160_byte_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hash160_byte_tx_if rb ();
    hash160_byte_tx_if hb ();

    hash160_byte_tx #(.HEX_ASCII(1'b0)) u_raw (
        .clk (clk),
        .rst (rst),
        .bus (rb.slave)
    );

    hash160_byte_tx #(.HEX_ASCII(1'b1)) u_hex (
        .clk (clk),
        .rst (rst),
        .bus (hb.slave)
    );

    localparam logic [159:0] D_A =
        160'h0123456789abcdeffedcba9876543210a5a55a5a;
    localparam logic [159:0] D_H =
        160'hab00000000000000000000000000000000000cff;
    localparam logic [159:0] D_R =
        160'hffeeddccbbaa99887766554433221100ffeeddcc;

    int errors = 0;
    int checks = 0;
    int xfer_raw = 0;
    int xfer_hex = 0;
    logic [8:0] exp_raw[$];
    logic [8:0] exp_hex[$];

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Reference: symbol k is byte k (or nibble k) of the digest, MSB first.
    task automatic push_exp(bit hex, logic [159:0] d);
        logic [7:0] b;
        logic [3:0] n;
        if (!hex) begin
            for (int k = 0; k < 20; k++) begin
                b = 8'((d >> (8 * (19 - k))) & 160'hff);
                exp_raw.push_back({k == 19, b});
            end
        end else begin
            for (int k = 0; k < 40; k++) begin
                n = 4'((d >> (4 * (39 - k))) & 160'hf);
                if (n < 10) b = 8'd48 + {4'd0, n};
                else        b = 8'd97 + {4'd0, n} - 8'd10;
                exp_hex.push_back({k == 39, b});
            end
        end
    endtask

    task automatic drive(bit hex, logic v, logic [159:0] d);
        if (hex) begin
            hb.i_valid = v;
            hb.i_digest = d;
        end else begin
            rb.i_valid = v;
            rb.i_digest = d;
        end
    endtask

    task automatic set_rdy(bit hex, logic r);
        if (hex) hb.i_ready = r;
        else     rb.i_ready = r;
    endtask

    function automatic logic rdy(bit hex);
        return hex ? hb.o_ready : rb.o_ready;
    endfunction

    function automatic logic vld(bit hex);
        return hex ? hb.o_valid : rb.o_valid;
    endfunction

    task automatic capture(bit hex, logic [159:0] d);
        push_exp(hex, d);
        drive(hex, 1'b1, d);
        @(posedge clk) #1;
        drive(hex, 1'b0, ~d);
        chk("cap_valid", {31'd0, vld(hex)}, 32'd1);
        chk("cap_busy", {31'd0, rdy(hex)}, 32'd0);
    endtask

    // mode 0: ready high, 1: ready toggles, 2: ready random
    task automatic wait_idle(bit hex, int mode);
        int   n;
        logic r;
        n = 0;
        r = 1'b1;
        forever begin
            @(posedge clk) #1;
            n++;
            if (rdy(hex)) break;
            if (n >= 600) begin
                errors++;
                $display("FAIL idle_timeout: got busy expected idle");
                break;
            end
            if (mode == 1)      r = ~r;
            else if (mode == 2) r = 1'($urandom_range(0, 1));
            else                r = 1'b1;
            set_rdy(hex, r);
        end
    endtask

    task automatic wait_byte(logic [7:0] b);
        int n;
        n = 0;
        while (!(rb.o_valid && rb.o_data == b)) begin
            @(posedge clk) #1;
            n++;
            if (n >= 100) begin
                errors++;
                $display("FAIL byte_timeout: got %0h expected %0h",
                         rb.o_data, b);
                break;
            end
        end
    endtask

    task automatic chk_reset(string nm);
        chk({nm, "_rdy"}, {31'd0, rb.o_ready}, 32'd1);
        chk({nm, "_vld"}, {31'd0, rb.o_valid}, 32'd0);
        chk({nm, "_last"}, {31'd0, rb.o_last}, 32'd0);
        chk({nm, "_data"}, {24'd0, rb.o_data}, 32'd0);
        chk({nm, "_hex"},
            {20'd0, hb.o_ready, hb.o_valid, hb.o_last, 1'b0, hb.o_data},
            32'h800);
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && rb.o_valid && rb.i_ready) begin
            xfer_raw++;
            checks++;
            if (exp_raw.size() == 0) begin
                errors++;
                $display("FAIL raw_extra: got %h expected none", rb.o_data);
            end else begin
                e = exp_raw.pop_front();
                if ({rb.o_last, rb.o_data} !== e) begin
                    errors++;
                    $display("FAIL raw_sym: got last=%b data=%h expected last=%b data=%h",
                             rb.o_last, rb.o_data, e[8], e[7:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (!rst && hb.o_valid && hb.i_ready) begin
            xfer_hex++;
            checks++;
            if (exp_hex.size() == 0) begin
                errors++;
                $display("FAIL hex_extra: got %h expected none", hb.o_data);
            end else begin
                e = exp_hex.pop_front();
                if ({hb.o_last, hb.o_data} !== e) begin
                    errors++;
                    $display("FAIL hex_sym: got last=%b data=%h expected last=%b data=%h",
                             hb.o_last, hb.o_data, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        int c0;
        logic [159:0] d;
        drive(1'b0, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        set_rdy(1'b0, 1'b0);
        set_rdy(1'b1, 1'b0);

        // asynchronous reset between edges
        #12 rst = 1'b1;
        #1 chk_reset("rst_async");
        #9 rst = 1'b0;
        @(posedge clk) #1;
        for (int i = 0; i < 10; i++) begin
            chk_reset("rst_hold");
            @(posedge clk) #1;
        end

        // unthrottled raw stream with cycle-exact o_last / o_ready
        set_rdy(1'b0, 1'b1);
        c0 = xfer_raw;
        capture(1'b0, D_A);
        for (int k = 1; k <= 20; k++) begin
            chk("raw_vld", {31'd0, rb.o_valid}, 32'd1);
            chk("raw_last", {31'd0, rb.o_last}, {31'd0, k == 20});
            @(posedge clk) #1;
        end
        chk("raw_ready_back", {31'd0, rb.o_ready}, 32'd1);
        chk("raw_count", xfer_raw - c0, 32'd20);

        // backpressure: stall 3 cycles on 89, then toggle
        c0 = xfer_raw;
        capture(1'b0, D_A);
        wait_byte(8'h89);
        set_rdy(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold", {23'd0, rb.o_valid, rb.o_data}, 32'h189);
            if (i < 2) @(posedge clk) #1;
        end
        set_rdy(1'b0, 1'b1);
        wait_idle(1'b0, 1);
        chk("bp_count", xfer_raw - c0, 32'd20);
        chk("bp_drain", exp_raw.size(), 32'd0);

        // busy-ignore: i_valid with all-ff during byte index 2
        set_rdy(1'b0, 1'b1);
        capture(1'b0, D_A);
        @(posedge clk) #1;
        @(posedge clk) #1;
        chk("busy_idx2", {24'd0, rb.o_data}, 32'h45);
        drive(1'b0, 1'b1, {160{1'b1}});
        @(posedge clk) #1;
        drive(1'b0, 1'b0, '0);
        chk("busy_unaff", {23'd0, rb.o_ready, rb.o_data}, 32'h067);
        wait_idle(1'b0, 0);
        d = {$urandom, $urandom, $urandom, $urandom, $urandom};
        c0 = xfer_raw;
        capture(1'b0, d);
        wait_idle(1'b0, 0);
        chk("fresh_count", xfer_raw - c0, 32'd20);

        // hex mode
        set_rdy(1'b1, 1'b1);
        c0 = xfer_hex;
        capture(1'b1, D_H);
        wait_idle(1'b1, 0);
        chk("hex_count", xfer_hex - c0, 32'd40);
        chk("hex_drain", exp_hex.size(), 32'd0);

        // reset while byte index 7 is stalled
        set_rdy(1'b0, 1'b1);
        capture(1'b0, D_A);
        wait_byte(8'hef);
        set_rdy(1'b0, 1'b0);
        @(posedge clk) #1;
        chk("mid_stall", {23'd0, rb.o_valid, rb.o_data}, 32'h1ef);
        #2 rst = 1'b1;
        #1 chk_reset("rst_mid");
        exp_raw.delete();
        exp_hex.delete();
        #3 rst = 1'b0;
        @(posedge clk) #1;
        chk_reset("rst_mid_rel");
        set_rdy(1'b0, 1'b1);
        c0 = xfer_raw;
        capture(1'b0, D_R);
        chk("mid_first", {24'd0, rb.o_data}, 32'hff);
        wait_idle(1'b0, 0);
        chk("mid_count", xfer_raw - c0, 32'd20);

        // random digests under random backpressure
        for (int i = 0; i < 8; i++) begin
            bit hex;
            hex = i[0];
            d = {$urandom, $urandom, $urandom, $urandom, $urandom};
            set_rdy(hex, 1'($urandom_range(0, 1)));
            capture(hex, d);
            wait_idle(hex, 2);
            chk("rnd_drain", exp_raw.size() + exp_hex.size(), 32'd0);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
